// File: rtl/mem_bus_master_if.sv
// Core-side request/response channel of the memory bus master.
// The core drives requests through the master modport; the bus master
// block accepts them and returns responses through the slave modport.
interface mem_bus_master_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 8
) ();

    // Request channel (core -> bus master)
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;

    // Response channel (bus master -> core)
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic                  rsp_write;
    logic [DATA_WIDTH-1:0] rsp_rdata;

    // Core side: issues requests, consumes responses
    modport master (
        output req_valid,
        output req_write,
        output req_addr,
        output req_wdata,
        input  req_ready,
        input  rsp_valid,
        input  rsp_write,
        input  rsp_rdata,
        output rsp_ready
    );

    // Bus master side: accepts requests, produces responses
    modport slave (
        input  req_valid,
        input  req_write,
        input  req_addr,
        input  req_wdata,
        output req_ready,
        output rsp_valid,
        output rsp_write,
        output rsp_rdata,
        input  rsp_ready
    );

endinterface

// File: rtl/mem_bus_master.sv
// Initiator for the shared-bus memory. Takes one request at a time from the
// core, sequences addr/wr/rd and the bidirectional data bus, and returns a
// response. The memory has a one-cycle registered read, optionally stretched
// by RD_WAIT extra cycles with mem_rd held high.
//
// Every memory-side output and every response field is a register. The
// output decode works on the state being entered (state_next), so strobes
// change on the same edge as the state they belong to.
module mem_bus_master #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 8,
    parameter int RD_WAIT    = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    mem_bus_master_if.slave       core,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_wr,
    output logic                  mem_rd,
    inout  wire  [DATA_WIDTH-1:0] mem_data
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_RD_ADDR,
        S_RD_WAIT,
        S_RD_DATA,
        S_RESP
    } state_t;

    // Wait counter counts down to zero inside S_RD_WAIT, so it is loaded
    // with one less than the number of wait cycles wanted.
    localparam bit       HAS_WAIT  = (RD_WAIT > 0);
    localparam logic [3:0] WAIT_LOAD = HAS_WAIT ? 4'(RD_WAIT - 1) : 4'd0;

    state_t                state_reg,     state_next;
    logic [ADDR_WIDTH-1:0] mem_addr_reg,  mem_addr_next;
    logic [DATA_WIDTH-1:0] wdata_reg,     wdata_next;
    logic                  mem_wr_reg,    mem_wr_next;
    logic                  mem_rd_reg,    mem_rd_next;
    logic                  drive_en_reg,  drive_en_next;
    logic                  rsp_valid_reg, rsp_valid_next;
    logic                  rsp_write_reg, rsp_write_next;
    logic [DATA_WIDTH-1:0] rsp_rdata_reg, rsp_rdata_next;
    logic [3:0]            wait_cnt_reg,  wait_cnt_next;

    logic                  accept;

    // A request is taken only in IDLE; fields seen in any other state are ignored.
    assign accept = (state_reg == S_IDLE) && core.req_valid;

    // State and all registered outputs; reset aborts any transaction silently.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= S_IDLE;
            mem_addr_reg  <= '0;
            wdata_reg     <= '0;
            mem_wr_reg    <= 1'b0;
            mem_rd_reg    <= 1'b0;
            drive_en_reg  <= 1'b0;
            rsp_valid_reg <= 1'b0;
            rsp_write_reg <= 1'b0;
            rsp_rdata_reg <= '0;
            wait_cnt_reg  <= 4'd0;
        end else begin
            state_reg     <= state_next;
            mem_addr_reg  <= mem_addr_next;
            wdata_reg     <= wdata_next;
            mem_wr_reg    <= mem_wr_next;
            mem_rd_reg    <= mem_rd_next;
            drive_en_reg  <= drive_en_next;
            rsp_valid_reg <= rsp_valid_next;
            rsp_write_reg <= rsp_write_next;
            rsp_rdata_reg <= rsp_rdata_next;
            wait_cnt_reg  <= wait_cnt_next;
        end
    end

    // Next-state decode: fixed one-cycle write, address/wait/data read phases.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                if (core.req_valid) begin
                    state_next = core.req_write ? S_WRITE : S_RD_ADDR;
                end
            end
            S_WRITE: begin
                state_next = S_RESP;
            end
            S_RD_ADDR: begin
                state_next = HAS_WAIT ? S_RD_WAIT : S_RD_DATA;
            end
            S_RD_WAIT: begin
                if (wait_cnt_reg == 4'd0) begin
                    state_next = S_RD_DATA;
                end
            end
            S_RD_DATA: begin
                state_next = S_RESP;
            end
            S_RESP: begin
                if (core.rsp_ready) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Output decode: strobes follow the state being entered, data fields
    // are captured on the transitions that produce them and held otherwise.
    always_comb begin
        mem_addr_next  = mem_addr_reg;
        wdata_next     = wdata_reg;
        rsp_write_next = rsp_write_reg;
        rsp_rdata_next = rsp_rdata_reg;
        wait_cnt_next  = wait_cnt_reg;

        // mem_wr and drive enable only ever in WRITE, mem_rd only in the read
        // phases; RESP and IDLE separate any change of direction on the bus.
        mem_wr_next    = (state_next == S_WRITE);
        drive_en_next  = (state_next == S_WRITE);
        mem_rd_next    = (state_next == S_RD_ADDR) ||
                         (state_next == S_RD_WAIT) ||
                         (state_next == S_RD_DATA);
        rsp_valid_next = (state_next == S_RESP);

        case (state_reg)
            S_IDLE: begin
                if (accept) begin
                    mem_addr_next = core.req_addr;
                    wdata_next    = core.req_wdata;
                end
            end
            S_WRITE: begin
                rsp_write_next = 1'b1;
                rsp_rdata_next = '0;
            end
            S_RD_ADDR: begin
                wait_cnt_next = WAIT_LOAD;
            end
            S_RD_WAIT: begin
                if (wait_cnt_reg != 4'd0) begin
                    wait_cnt_next = wait_cnt_reg - 4'd1;
                end
            end
            S_RD_DATA: begin
                // Memory output is on the bus during this cycle.
                rsp_write_next = 1'b0;
                rsp_rdata_next = mem_data;
            end
            default: begin
            end
        endcase
    end

    assign core.req_ready = (state_reg == S_IDLE);
    assign core.rsp_valid = rsp_valid_reg;
    assign core.rsp_write = rsp_write_reg;
    assign core.rsp_rdata = rsp_rdata_reg;

    assign mem_addr = mem_addr_reg;
    assign mem_wr   = mem_wr_reg;
    assign mem_rd   = mem_rd_reg;

    // Bus is released whenever the registered drive enable is low.
    assign mem_data = drive_en_reg ? wdata_reg : {DATA_WIDTH{1'bz}};

endmodule

// File: tb/tb_mem_bus_master.sv
// Bench for mem_bus_master: two builds (RD_WAIT=0 and RD_WAIT=3), each with
// its own registered-read memory on the shared data bus. A shadow memory
// array predicts read data; latencies and strobe counts come from the
// transaction timing rules.
module tb_mem_bus_master;

    localparam int AW   = 5;
    localparam int DW   = 8;
    localparam int RDW0 = 0;
    localparam int RDW1 = 3;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    // Per-instance stimulus and observation
    logic          req_valid [2];
    logic          req_write [2];
    logic [AW-1:0] req_addr  [2];
    logic [DW-1:0] req_wdata [2];
    logic          rsp_ready [2];

    logic          req_ready_s [2];
    logic          rsp_valid_s [2];
    logic          rsp_write_s [2];
    logic [DW-1:0] rsp_rdata_s [2];
    logic [AW-1:0] mem_addr_s  [2];
    logic          mem_wr_s    [2];
    logic          mem_rd_s    [2];
    logic [DW-1:0] bus_s       [2];

    wire  [DW-1:0] mem_data0;
    wire  [DW-1:0] mem_data1;

    mem_bus_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) if0 ();
    mem_bus_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) if1 ();

    assign if0.req_valid = req_valid[0];
    assign if0.req_write = req_write[0];
    assign if0.req_addr  = req_addr[0];
    assign if0.req_wdata = req_wdata[0];
    assign if0.rsp_ready = rsp_ready[0];
    assign if1.req_valid = req_valid[1];
    assign if1.req_write = req_write[1];
    assign if1.req_addr  = req_addr[1];
    assign if1.req_wdata = req_wdata[1];
    assign if1.rsp_ready = rsp_ready[1];

    assign req_ready_s[0] = if0.req_ready;
    assign rsp_valid_s[0] = if0.rsp_valid;
    assign rsp_write_s[0] = if0.rsp_write;
    assign rsp_rdata_s[0] = if0.rsp_rdata;
    assign req_ready_s[1] = if1.req_ready;
    assign rsp_valid_s[1] = if1.rsp_valid;
    assign rsp_write_s[1] = if1.rsp_write;
    assign rsp_rdata_s[1] = if1.rsp_rdata;
    assign bus_s[0]       = mem_data0;
    assign bus_s[1]       = mem_data1;

    mem_bus_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_WAIT(RDW0)) dut0 (
        .clk      (clk),
        .rst      (rst),
        .core     (if0.slave),
        .mem_addr (mem_addr_s[0]),
        .mem_wr   (mem_wr_s[0]),
        .mem_rd   (mem_rd_s[0]),
        .mem_data (mem_data0)
    );

    mem_bus_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_WAIT(RDW1)) dut1 (
        .clk      (clk),
        .rst      (rst),
        .core     (if1.slave),
        .mem_addr (mem_addr_s[1]),
        .mem_wr   (mem_wr_s[1]),
        .mem_rd   (mem_rd_s[1]),
        .mem_data (mem_data1)
    );

    // Memories: registered read while mem_rd, write on mem_wr, drive bus while mem_rd
    logic [DW-1:0] ram0 [32];
    logic [DW-1:0] ram1 [32];
    logic [DW-1:0] mem_q0;
    logic [DW-1:0] mem_q1;

    assign mem_data0 = mem_rd_s[0] ? mem_q0 : {DW{1'bz}};
    assign mem_data1 = mem_rd_s[1] ? mem_q1 : {DW{1'bz}};

    always @(posedge clk) begin
        if (mem_rd_s[0]) mem_q0 <= ram0[mem_addr_s[0]];
        if (mem_wr_s[0]) ram0[mem_addr_s[0]] <= mem_data0;
        if (mem_rd_s[1]) mem_q1 <= ram1[mem_addr_s[1]];
        if (mem_wr_s[1]) ram1[mem_addr_s[1]] <= mem_data1;
    end

    // Reference model: what each location should hold, and whether it is known
    logic [DW-1:0] ref_mem [2][32];
    bit            ref_ok  [2][32];

    int checks = 0;
    int errors = 0;
    int txn_no = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Random request fields while the block is busy; they must be ignored
    task automatic junk(input int i);
        req_valid[i] = 1'($urandom);
        req_write[i] = 1'($urandom);
        req_addr[i]  = AW'($urandom);
        req_wdata[i] = DW'($urandom);
    endtask

    task automatic do_txn(input int i, input bit wr, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wdata, input int bp);
        int lat;
        int rd_cnt;
        int wr_cnt;
        int guard;
        int rdw;
        logic [DW-1:0] exp_data;
        rdw      = (i == 0) ? RDW0 : RDW1;
        exp_data = wr ? '0 : ref_mem[i][addr];
        guard    = 0;
        @(negedge clk);
        while (!req_ready_s[i] && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("req_ready_idle", req_ready_s[i], 1);
        req_valid[i] = 1'b1;
        req_write[i] = wr;
        req_addr[i]  = addr;
        req_wdata[i] = wdata;
        rsp_ready[i] = (bp == 0);
        @(posedge clk);
        lat    = 1;
        rd_cnt = 0;
        wr_cnt = 0;
        @(negedge clk);
        while (!rsp_valid_s[i] && lat < 40) begin
            check("mem_addr_hold", mem_addr_s[i], addr);
            check("req_ready_busy", req_ready_s[i], 0);
            check("rd_wr_excl", mem_rd_s[i] & mem_wr_s[i], 0);
            if (mem_rd_s[i]) rd_cnt++;
            if (mem_wr_s[i]) begin
                wr_cnt++;
                check("wr_bus_data", bus_s[i], wdata);
            end
            junk(i);
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        if (!rsp_valid_s[i]) begin
            check("rsp_timeout", 0, 1);
            req_valid[i] = 1'b0;
            rsp_ready[i] = 1'b0;
            return;
        end
        req_valid[i] = 1'b0;
        check("latency", lat, wr ? 2 : 3 + rdw);
        check("mem_rd_cycles", rd_cnt, wr ? 0 : 2 + rdw);
        check("mem_wr_cycles", wr_cnt, wr ? 1 : 0);
        check("rsp_write", rsp_write_s[i], wr);
        check("rsp_rdata", rsp_rdata_s[i], exp_data);
        check("mem_addr_resp", mem_addr_s[i], addr);
        for (int k = 0; k < bp; k++) begin
            junk(i);
            @(posedge clk);
            @(negedge clk);
            check("bp_valid", rsp_valid_s[i], 1);
            check("bp_rdata", rsp_rdata_s[i], exp_data);
            check("bp_req_ready", req_ready_s[i], 0);
            check("bp_bus_idle", mem_rd_s[i] | mem_wr_s[i], 0);
        end
        req_valid[i] = 1'b0;
        rsp_ready[i] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rsp_done", rsp_valid_s[i], 0);
        check("back_idle", req_ready_s[i], 1);
        rsp_ready[i] = 1'b0;
        if (wr) begin
            ref_mem[i][addr] = wdata;
            ref_ok[i][addr]  = 1'b1;
        end
        txn_no++;
        $display("txn %0d inst%0d %s addr=%0d data=0x%02h lat=%0d bp=%0d",
                 txn_no, i, wr ? "WR" : "RD", addr, wr ? wdata : rsp_rdata_s[i], lat, bp);
    endtask

    task automatic check_reset_state(input int i, input string tag);
        check({tag, "_mem_rd"},    mem_rd_s[i], 0);
        check({tag, "_mem_wr"},    mem_wr_s[i], 0);
        check({tag, "_rsp_valid"}, rsp_valid_s[i], 0);
        check({tag, "_req_ready"}, req_ready_s[i], 1);
        check({tag, "_mem_addr"},  mem_addr_s[i], 0);
        check({tag, "_rsp_rdata"}, rsp_rdata_s[i], 0);
        check({tag, "_rsp_write"}, rsp_write_s[i], 0);
    endtask

    // Start a transaction on instance 0, reset it in its first busy cycle
    task automatic reset_mid(input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
        int seen;
        @(negedge clk);
        check("abort_idle", req_ready_s[0], 1);
        req_valid[0] = 1'b1;
        req_write[0] = wr;
        req_addr[0]  = addr;
        req_wdata[0] = wdata;
        @(posedge clk);
        @(negedge clk);
        req_valid[0] = 1'b0;
        check(wr ? "abort_in_write" : "abort_in_rd_addr", wr ? mem_wr_s[0] : mem_rd_s[0], 1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_reset_state(0, wr ? "wr_abort" : "rd_abort");
        rsp_ready[0] = 1'b1;
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (rsp_valid_s[0]) seen++;
        end
        check("no_rsp_after_abort", seen, 0);
        rsp_ready[0] = 1'b0;
        if (wr) ref_ok[0][addr] = 1'b0;
        txn_no++;
        $display("txn %0d inst0 %s addr=%0d aborted by reset", txn_no, wr ? "WR" : "RD", addr);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1);
    end

    initial begin
        int i;
        bit wr;
        logic [AW-1:0] a;
        int tries;
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            req_valid[k] = 1'b0;
            req_write[k] = 1'b0;
            req_addr[k]  = '0;
            req_wdata[k] = '0;
            rsp_ready[k] = 1'b0;
            for (int m = 0; m < 32; m++) begin
                ref_mem[k][m] = '0;
                ref_ok[k][m]  = 1'b0;
            end
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_reset_state(0, "reset0");
        check_reset_state(1, "reset1");

        // Directed: write/read, address boundaries, backpressure, direction changes
        do_txn(0, 1'b1, 5'd5,  8'hA5, 0);
        do_txn(0, 1'b0, 5'd5,  8'h00, 0);
        do_txn(0, 1'b1, 5'd0,  8'h3C, 1);
        do_txn(0, 1'b1, 5'd31, 8'hC3, 0);
        do_txn(0, 1'b0, 5'd0,  8'h00, 0);
        do_txn(0, 1'b0, 5'd31, 8'h00, 0);
        do_txn(0, 1'b0, 5'd5,  8'h00, 4);
        do_txn(0, 1'b1, 5'd9,  8'h96, 0);
        do_txn(0, 1'b0, 5'd9,  8'h00, 2);

        // Directed: stretched read build
        do_txn(1, 1'b1, 5'd7,  8'h5E, 0);
        do_txn(1, 1'b0, 5'd7,  8'h00, 0);
        do_txn(1, 1'b0, 5'd7,  8'h00, 3);

        // Randomized mix across both builds
        for (int n = 0; n < 60; n++) begin
            i  = int'($urandom_range(0, 1));
            wr = 1'($urandom);
            a  = AW'($urandom);
            if (!wr) begin
                tries = 0;
                while (!ref_ok[i][a] && tries < 200) begin
                    a = AW'($urandom);
                    tries++;
                end
                if (!ref_ok[i][a]) wr = 1'b1;
            end
            do_txn(i, wr, a, DW'($urandom), int'($urandom_range(0, 3)));
        end

        // Reset during RD_ADDR and during WRITE
        reset_mid(1'b0, 5'd5, 8'h00);
        reset_mid(1'b1, 5'd12, 8'h77);

        // Still functional afterwards
        do_txn(0, 1'b1, 5'd12, 8'h81, 0);
        do_txn(0, 1'b0, 5'd12, 8'h00, 1);
        do_txn(1, 1'b0, 5'd7,  8'h00, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_bus_master.md
Name: mem_bus_master

Overview:
- Initiator side of the shared-bus memory interface: addr, wr, rd, and a bidirectional data bus.
- Accepts single read/write requests from the core over a valid/ready handshake and sequences the memory bus with correct timing.
- Drives the data bus only during write cycles, captures read data after the memory's one-cycle registered latency, and returns a response over a valid/ready handshake.
- Sits between the VeriRISC controller/datapath and the memory block.

Parameters:
- ADDR_WIDTH, 5, width of memory address.
- DATA_WIDTH, 8, width of data bus.
- RD_WAIT, 0, extra cycles mem_rd is held before read data is sampled (0..15).

Ports:
- clk  input  1  single clock, all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  block can accept a request.
- req_write  input  1  1 = write, 0 = read.
- req_addr  input  ADDR_WIDTH  request address.
- req_wdata  input  DATA_WIDTH  write data.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  consumer accepts response.
- rsp_write  output  1  response belongs to a write (ack only).
- rsp_rdata  output  DATA_WIDTH  read data; 0 for write acks.
- mem_addr  output  ADDR_WIDTH  memory address.
- mem_wr  output  1  memory write strobe.
- mem_rd  output  1  memory read enable; memory drives data while high.
- mem_data  inout  DATA_WIDTH  shared data bus; driven by this block only while its internal drive enable is set, else high-Z.

Behaviour:
- All outputs are registered except req_ready, which is decoded from state, and mem_data, which is a tristate driven from the registered drive enable and write-data register.
- Reset (sync, active-high):
  - state=IDLE; mem_wr=0, mem_rd=0, drive enable=0 (bus high-Z after the reset edge).
  - mem_addr=0, rsp_valid=0, rsp_write=0, rsp_rdata=0, wait counter=0.
  - Reset mid-transaction aborts it with no response; a write is not guaranteed to have completed.
- States: IDLE, WRITE, RD_ADDR, RD_WAIT, RD_DATA, RESP.
- IDLE:
  - req_ready=1 (only in IDLE).
  - On req_valid, latch addr/wdata/write.
  - If write: go to WRITE with mem_wr=1 and drive enable=1 in that cycle.
  - If read: go to RD_ADDR with mem_rd=1.
- WRITE:
  - Exactly 1 cycle; memory writes at the closing edge.
  - Next: RESP with mem_wr=0, drive enable=0, rsp_valid=1, rsp_write=1, rsp_rdata=0.
- RD_ADDR:
  - mem_rd=1; memory registers ram[addr] at the closing edge.
  - Next: RD_WAIT if RD_WAIT>0 (counter loaded with RD_WAIT-1), else RD_DATA.
- RD_WAIT:
  - mem_rd held at 1; counter decrements.
  - Exit to RD_DATA when counter=0.
- RD_DATA:
  - mem_rd=1, bus carries memory output.
  - At the closing edge: rsp_rdata<=mem_data; go to RESP with mem_rd=0, rsp_valid=1, rsp_write=0.
- RESP:
  - rsp_valid and rsp_rdata held stable until rsp_ready=1.
  - On that edge: rsp_valid=0, go to IDLE.
  - No new request is accepted before the response completes (one outstanding).
- Timing:
  - Read latency, request-accept edge to rsp_valid high: 3+RD_WAIT edges.
  - Write: 2 edges.
  - Minimum back-to-back spacing: 1 IDLE cycle between transactions.
- Bus rules:
  - mem_rd and mem_wr are never high in the same cycle.
  - Drive enable is never high while mem_rd=1.
  - Every rd->write and write->rd change has at least one cycle with both deasserted (RESP/IDLE), so there is no contention.
- mem_addr is held constant for the whole transaction and keeps its last value in IDLE.
- Request fields are ignored outside IDLE.

Test Plan:
- Write then read: write addr 5 data 0xA5, ack with rsp_write=1 → read addr 5 gives rsp_rdata=0xA5 exactly 3 edges after accept (RD_WAIT=0).
- Address boundaries: write 0x3C@0 and 0xC3@31, read both back → 0x3C and 0xC3, with mem_addr stable each transaction.
- Response backpressure: read with rsp_ready low 4 cycles → rsp_valid/rsp_rdata stable, req_ready=0; releasing rsp_ready returns to IDLE the next edge.
- Bus contention check: write immediately following a read, and a read following a write → checker sees mem_data never driven by both sides (no X), and no cycle with mem_rd&mem_wr.
- RD_WAIT=3 build: read addr 7 holding 0x5E → mem_rd high 5 cycles, rsp_valid 6 edges after accept, data 0x5E.
- Reset mid-read (during RD_ADDR) and mid-write (during WRITE) → after the reset edge: mem_rd=mem_wr=0, bus high-Z, rsp_valid=0, req_ready=1; no response is ever issued for the aborted request.
